id_ex_hazard_reg: RTL and testbench
===================================

Name: id_ex_hazard_reg

Overview:
- ID/EX pipeline register sitting directly downstream of the decode-stage control unit.
- Captures the seven control signals (Branch, MemRead, MemToReg, ALUOp, MemWrite, ALUSrc, RegWrite), operands, immediate and register indices each cycle for the EX stage.
- Detects load-use hazards against the instruction currently in EX. On a hazard it inserts a bubble and stalls PC and IF/ID.
- Supports branch flush, global hold, and a saturating count of load-use bubbles.

Parameters:
- XLEN, 64, datapath width of PC, operands and immediate.
- RA_W, 5, register index width.
- CNT_W, 32, width of the load-use bubble counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- id_valid  in  1  ID holds a real instruction.
- id_branch, id_mem_read, id_mem_to_reg, id_mem_write, id_alu_src, id_reg_write  in  1 each  control-unit outputs.
- id_alu_op  in  2  control-unit ALUOp.
- id_pc  in  XLEN  PC of ID instruction.
- id_rs1_data, id_rs2_data, id_imm  in  XLEN  register-file reads and sign-extended immediate.
- id_rs1, id_rs2, id_rd  in  RA_W  register indices.
- id_funct4  in  4  {instr[30], instr[14:12]} for ALU control.
- flush  in  1  branch taken; kill ID instruction.
- hold  in  1  global pipeline freeze (e.g. memory wait).
- ex_valid, ex_branch, ex_mem_read, ex_mem_to_reg, ex_mem_write, ex_alu_src, ex_reg_write  out  1 each  registered.
- ex_alu_op  out  2  registered.
- ex_pc, ex_rs1_data, ex_rs2_data, ex_imm  out  XLEN  registered.
- ex_rs1, ex_rs2, ex_rd  out  RA_W  registered.
- ex_funct4  out  4  registered.
- stall  out  1  combinational load-use stall.
- pc_write, if_id_write  out  1 each  = ~stall.
- bubble_count  out  CNT_W  saturating count of load-use bubbles.

Behaviour:
- Reset (synchronous, active-high, highest priority): all ex_* outputs 0, bubble_count 0. Reset mid-operation discards the in-flight instruction.
- uses_rs2 = (id_alu_src==0) | id_mem_write.
- hazard = id_valid & ex_valid & ex_mem_read & (ex_rd!=0) & ((ex_rd==id_rs1) | (uses_rs2 & ex_rd==id_rs2)).
- stall = hazard & ~flush. It is asserted in the same cycle as hazard, with zero latency, and is independent of hold.
- Per-edge priority when not in reset:
  - (1) flush=1: bubble, even if hold=1.
  - (2) hold=1: all ex_* keep their values.
  - (3) hazard=1: bubble.
  - (4) otherwise: capture all id_* into ex_*, ex_valid = id_valid.
- Bubble definition: ex_valid and all seven control outputs go to 0; data/index outputs are don't-care. A bubble must never write the register file or memory.
- Load-use produces exactly one bubble: next cycle ex_mem_read=0, so hazard drops and the held ID instruction is captured.
- bubble_count increments by 1 only on edges taking priority (3). It saturates at 2^CNT_W-1 with no wrap, and is unaffected by flush and hold edges.
- Registered outputs have 1-cycle latency ID→EX.
- id_valid=0 captures as ex_valid=0 with controls passed through. Downstream gates on ex_valid.

Test Plan:
- Normal flow: id_valid=1, R-type (reg_write=1, alu_op=2'b10, rd=5), id_pc=0x100 → next edge ex_reg_write=1, ex_alu_op=2'b10, ex_rd=5, ex_pc=0x100, stall=0.
- Load-use: EX holds ld rd=7; ID has add rs1=7 → stall=1, pc_write=0. Next edge ex_valid=0 with all controls 0, bubble_count=1. Following edge ex captures the add, stall=0.
- No false stall:
  - EX ld rd=0 with ID rs1=0 → stall=0.
  - EX ld rd=3 with ID addi (alu_src=1, rs2 field=3) → stall=0.
  - The same case with sd (mem_write=1, rs2=3) → stall=1.
- Flush priority: hazard present with flush=1 and hold=1 → stall=0; next edge bubble, bubble_count unchanged.
- Hold: hold=1 for 3 cycles while id_* changes → ex_* constant. Release → captures current id_*.
- Reset mid-stream plus saturation:
  - reset=1 during a stall → next edge all ex_*=0, bubble_count=0.
  - With CNT_W=2, 5 consecutive load-use bubbles → bubble_count=3.

Source files
------------

// File: rtl/id_ex_hazard_reg.sv
// ID/EX pipeline register with load-use hazard detection.
// Inserts one bubble per load-use, honours flush and hold, counts bubbles.
module id_ex_hazard_reg #(
    parameter int XLEN  = 64,
    parameter int RA_W  = 5,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic             id_branch,
    input  logic             id_mem_read,
    input  logic             id_mem_to_reg,
    input  logic             id_mem_write,
    input  logic             id_alu_src,
    input  logic             id_reg_write,
    input  logic [1:0]       id_alu_op,
    input  logic [XLEN-1:0]  id_pc,
    input  logic [XLEN-1:0]  id_rs1_data,
    input  logic [XLEN-1:0]  id_rs2_data,
    input  logic [XLEN-1:0]  id_imm,
    input  logic [RA_W-1:0]  id_rs1,
    input  logic [RA_W-1:0]  id_rs2,
    input  logic [RA_W-1:0]  id_rd,
    input  logic [3:0]       id_funct4,
    input  logic             flush,
    input  logic             hold,
    output logic             ex_valid,
    output logic             ex_branch,
    output logic             ex_mem_read,
    output logic             ex_mem_to_reg,
    output logic             ex_mem_write,
    output logic             ex_alu_src,
    output logic             ex_reg_write,
    output logic [1:0]       ex_alu_op,
    output logic [XLEN-1:0]  ex_pc,
    output logic [XLEN-1:0]  ex_rs1_data,
    output logic [XLEN-1:0]  ex_rs2_data,
    output logic [XLEN-1:0]  ex_imm,
    output logic [RA_W-1:0]  ex_rs1,
    output logic [RA_W-1:0]  ex_rs2,
    output logic [RA_W-1:0]  ex_rd,
    output logic [3:0]       ex_funct4,
    output logic             stall,
    output logic             pc_write,
    output logic             if_id_write,
    output logic [CNT_W-1:0] bubble_count
);

    typedef struct packed {
        logic       branch;
        logic       mem_read;
        logic       mem_to_reg;
        logic       mem_write;
        logic       alu_src;
        logic       reg_write;
        logic [1:0] alu_op;
    } ctrl_t;

    typedef struct packed {
        logic            valid;
        ctrl_t           ctrl;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [RA_W-1:0] rs1;
        logic [RA_W-1:0] rs2;
        logic [RA_W-1:0] rd;
        logic [3:0]      funct4;
    } id_ex_t;

    id_ex_t id_in;
    id_ex_t ex_q;
    id_ex_t ex_d;

    logic uses_rs2;
    logic rs1_match;
    logic rs2_match;
    logic hazard;

    logic sel_flush;
    logic sel_hold;
    logic sel_bubble;
    logic sel_capture;

    logic [CNT_W-1:0] cnt_q;
    logic             cnt_sat;

    // Bundle the decode-stage signals into one record
    always_comb begin
        id_in                 = '0;
        id_in.valid           = id_valid;
        id_in.ctrl.branch     = id_branch;
        id_in.ctrl.mem_read   = id_mem_read;
        id_in.ctrl.mem_to_reg = id_mem_to_reg;
        id_in.ctrl.mem_write  = id_mem_write;
        id_in.ctrl.alu_src    = id_alu_src;
        id_in.ctrl.reg_write  = id_reg_write;
        id_in.ctrl.alu_op     = id_alu_op;
        id_in.pc              = id_pc;
        id_in.rs1_data        = id_rs1_data;
        id_in.rs2_data        = id_rs2_data;
        id_in.imm             = id_imm;
        id_in.rs1             = id_rs1;
        id_in.rs2             = id_rs2;
        id_in.rd              = id_rd;
        id_in.funct4          = id_funct4;
    end

    // Load-use detection against the instruction currently in EX
    always_comb begin
        uses_rs2  = ~id_alu_src | id_mem_write;
        rs1_match = (ex_q.rd == id_rs1);
        rs2_match = uses_rs2 & (ex_q.rd == id_rs2);
        hazard    = id_valid
                  & ex_q.valid
                  & ex_q.ctrl.mem_read
                  & (ex_q.rd != '0)
                  & (rs1_match | rs2_match);
    end

    assign stall       = hazard & ~flush;
    assign pc_write    = ~stall;
    assign if_id_write = ~stall;

    // Mutually exclusive edge actions: flush > hold > hazard > capture
    always_comb begin
        sel_flush   = flush;
        sel_hold    = ~flush & hold;
        sel_bubble  = ~flush & ~hold & hazard;
        sel_capture = ~flush & ~hold & ~hazard;
    end

    // Next EX contents; a bubble clears valid and every control bit
    always_comb begin
        ex_d = ex_q;
        unique case (1'b1)
            sel_flush: begin
                ex_d.valid = 1'b0;
                ex_d.ctrl  = '0;
            end
            sel_hold: begin
                ex_d = ex_q;
            end
            sel_bubble: begin
                ex_d.valid = 1'b0;
                ex_d.ctrl  = '0;
            end
            sel_capture: begin
                ex_d = id_in;
            end
            default: begin
                ex_d = ex_q;
            end
        endcase
    end

    // EX stage register
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

    assign cnt_sat = (cnt_q == {CNT_W{1'b1}});

    // Saturating count of load-use bubbles only
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (sel_bubble && !cnt_sat) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign bubble_count  = cnt_q;

    assign ex_valid      = ex_q.valid;
    assign ex_branch     = ex_q.ctrl.branch;
    assign ex_mem_read   = ex_q.ctrl.mem_read;
    assign ex_mem_to_reg = ex_q.ctrl.mem_to_reg;
    assign ex_mem_write  = ex_q.ctrl.mem_write;
    assign ex_alu_src    = ex_q.ctrl.alu_src;
    assign ex_reg_write  = ex_q.ctrl.reg_write;
    assign ex_alu_op     = ex_q.ctrl.alu_op;
    assign ex_pc         = ex_q.pc;
    assign ex_rs1_data   = ex_q.rs1_data;
    assign ex_rs2_data   = ex_q.rs2_data;
    assign ex_imm        = ex_q.imm;
    assign ex_rs1        = ex_q.rs1;
    assign ex_rs2        = ex_q.rs2;
    assign ex_rd         = ex_q.rd;
    assign ex_funct4     = ex_q.funct4;

endmodule

// File: tb/tb_id_ex_hazard_reg.sv
// Directed bench for id_ex_hazard_reg.
// Vector table plus a load-use saturation sequence.
module tb_id_ex_hazard_reg;

    localparam int XLEN = 64;
    localparam int RA_W = 5;

    // {branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write, alu_op}
    localparam logic [7:0] C_R    = 8'b0000_0110;
    localparam logic [7:0] C_LD   = 8'b0110_1100;
    localparam logic [7:0] C_ADDI = 8'b0000_1110;
    localparam logic [7:0] C_SD   = 8'b0001_1000;

    typedef struct {
        logic            vld;
        logic [7:0]      ctrl;
        logic [XLEN-1:0] pc;
        logic [RA_W-1:0] rs1;
        logic [RA_W-1:0] rs2;
        logic [RA_W-1:0] rd;
        logic            fl;
        logic            hd;
        logic            rst;
        logic            e_stall;
        logic            c_stall;
        logic            e_vld;
        logic [7:0]      e_ctrl;
        logic            c_data;
        logic [XLEN-1:0] e_pc;
        logic [RA_W-1:0] e_rs1;
        logic [RA_W-1:0] e_rs2;
        logic [RA_W-1:0] e_rd;
        int              e_cnt;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset;
    logic            id_valid;
    logic            id_branch, id_mem_read, id_mem_to_reg;
    logic            id_mem_write, id_alu_src, id_reg_write;
    logic [1:0]      id_alu_op;
    logic [XLEN-1:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [RA_W-1:0] id_rs1, id_rs2, id_rd;
    logic [3:0]      id_funct4;
    logic            flush, hold;

    logic            ex_valid;
    logic            ex_branch, ex_mem_read, ex_mem_to_reg;
    logic            ex_mem_write, ex_alu_src, ex_reg_write;
    logic [1:0]      ex_alu_op;
    logic [XLEN-1:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [RA_W-1:0] ex_rs1, ex_rs2, ex_rd;
    logic [3:0]      ex_funct4;
    logic            stall, pc_write, if_id_write;
    logic [31:0]     bubble_count;

    logic            s_valid;
    logic            s_branch, s_mem_read, s_mem_to_reg;
    logic            s_mem_write, s_alu_src, s_reg_write;
    logic [1:0]      s_alu_op;
    logic [XLEN-1:0] s_pc, s_rs1_data, s_rs2_data, s_imm;
    logic [RA_W-1:0] s_rs1, s_rs2, s_rd;
    logic [3:0]      s_funct4;
    logic            s_stall, s_pc_write, s_if_id_write;
    logic [1:0]      s_bubble_count;

    id_ex_hazard_reg dut (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_branch(id_branch), .id_mem_read(id_mem_read),
        .id_mem_to_reg(id_mem_to_reg), .id_mem_write(id_mem_write),
        .id_alu_src(id_alu_src), .id_reg_write(id_reg_write),
        .id_alu_op(id_alu_op), .id_pc(id_pc),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rd(id_rd), .id_funct4(id_funct4),
        .flush(flush), .hold(hold),
        .ex_valid(ex_valid), .ex_branch(ex_branch),
        .ex_mem_read(ex_mem_read), .ex_mem_to_reg(ex_mem_to_reg),
        .ex_mem_write(ex_mem_write), .ex_alu_src(ex_alu_src),
        .ex_reg_write(ex_reg_write), .ex_alu_op(ex_alu_op),
        .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data),
        .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_funct4(ex_funct4), .stall(stall),
        .pc_write(pc_write), .if_id_write(if_id_write),
        .bubble_count(bubble_count)
    );

    id_ex_hazard_reg #(.CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_branch(id_branch), .id_mem_read(id_mem_read),
        .id_mem_to_reg(id_mem_to_reg), .id_mem_write(id_mem_write),
        .id_alu_src(id_alu_src), .id_reg_write(id_reg_write),
        .id_alu_op(id_alu_op), .id_pc(id_pc),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rd(id_rd), .id_funct4(id_funct4),
        .flush(flush), .hold(hold),
        .ex_valid(s_valid), .ex_branch(s_branch),
        .ex_mem_read(s_mem_read), .ex_mem_to_reg(s_mem_to_reg),
        .ex_mem_write(s_mem_write), .ex_alu_src(s_alu_src),
        .ex_reg_write(s_reg_write), .ex_alu_op(s_alu_op),
        .ex_pc(s_pc), .ex_rs1_data(s_rs1_data),
        .ex_rs2_data(s_rs2_data), .ex_imm(s_imm),
        .ex_rs1(s_rs1), .ex_rs2(s_rs2), .ex_rd(s_rd),
        .ex_funct4(s_funct4), .stall(s_stall),
        .pc_write(s_pc_write), .if_id_write(s_if_id_write),
        .bubble_count(s_bubble_count)
    );

    int total = 0;
    int bad   = 0;
    vec_t vt[$];

    function automatic logic [XLEN-1:0] f_rs1d(input logic [XLEN-1:0] x);
        return x ^ 64'hDEAD_0000_0000_BEEF;
    endfunction

    function automatic logic [XLEN-1:0] f_rs2d(input logic [XLEN-1:0] x);
        return x + 64'd7;
    endfunction

    function automatic logic [XLEN-1:0] f_imm(input logic [XLEN-1:0] x);
        return ~x;
    endfunction

    function automatic logic [3:0] f_f4(input logic [XLEN-1:0] x);
        logic [XLEN-1:0] t;
        t = x;
        return t[5:2];
    endfunction

    function automatic vec_t mk(
        input logic vld, input logic [7:0] ctrl,
        input logic [XLEN-1:0] pc, input logic [RA_W-1:0] rs1,
        input logic [RA_W-1:0] rs2, input logic [RA_W-1:0] rd,
        input logic fl, input logic hd, input logic rst,
        input logic e_stall, input logic c_stall,
        input logic e_vld, input logic [7:0] e_ctrl,
        input logic c_data, input logic [XLEN-1:0] e_pc,
        input logic [RA_W-1:0] e_rs1, input logic [RA_W-1:0] e_rs2,
        input logic [RA_W-1:0] e_rd, input int e_cnt);
        vec_t v;
        v.vld = vld; v.ctrl = ctrl; v.pc = pc;
        v.rs1 = rs1; v.rs2 = rs2; v.rd = rd;
        v.fl = fl; v.hd = hd; v.rst = rst;
        v.e_stall = e_stall; v.c_stall = c_stall;
        v.e_vld = e_vld; v.e_ctrl = e_ctrl;
        v.c_data = c_data; v.e_pc = e_pc;
        v.e_rs1 = e_rs1; v.e_rs2 = e_rs2; v.e_rd = e_rd;
        v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        reset         = v.rst;
        id_valid      = v.vld;
        id_branch     = v.ctrl[7];
        id_mem_read   = v.ctrl[6];
        id_mem_to_reg = v.ctrl[5];
        id_mem_write  = v.ctrl[4];
        id_alu_src    = v.ctrl[3];
        id_reg_write  = v.ctrl[2];
        id_alu_op     = v.ctrl[1:0];
        id_pc         = v.pc;
        id_rs1_data   = f_rs1d(v.pc);
        id_rs2_data   = f_rs2d(v.pc);
        id_imm        = f_imm(v.pc);
        id_funct4     = f_f4(v.pc);
        id_rs1        = v.rs1;
        id_rs2        = v.rs2;
        id_rd         = v.rd;
        flush         = v.fl;
        hold          = v.hd;
    endtask

    function automatic logic [7:0] ex_ctrl();
        return {ex_branch, ex_mem_read, ex_mem_to_reg, ex_mem_write,
                ex_alu_src, ex_reg_write, ex_alu_op};
    endfunction

    initial begin
        vec_t v;
        int   k;
        int   ebub;

        // Reset and normal R-type capture
        vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1,
                        0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        vt.push_back(mk(1, C_R, 'h100, 1, 2, 5, 0, 0, 0,
                        0, 1, 1, C_R, 1, 'h100, 1, 2, 5, 0));
        // Load then dependent add: one bubble, then capture
        vt.push_back(mk(1, C_LD, 'h104, 2, 0, 7, 0, 0, 0,
                        0, 1, 1, C_LD, 1, 'h104, 2, 0, 7, 0));
        vt.push_back(mk(1, C_R, 'h108, 7, 8, 9, 0, 0, 0,
                        1, 1, 0, 0, 0, 0, 0, 0, 0, 1));
        vt.push_back(mk(1, C_R, 'h108, 7, 8, 9, 0, 0, 0,
                        0, 1, 1, C_R, 1, 'h108, 7, 8, 9, 1));
        // Load to x0 never stalls
        vt.push_back(mk(1, C_LD, 'h10c, 1, 0, 0, 0, 0, 0,
                        0, 1, 1, C_LD, 1, 'h10c, 1, 0, 0, 1));
        vt.push_back(mk(1, C_R, 'h110, 0, 0, 4, 0, 0, 0,
                        0, 1, 1, C_R, 1, 'h110, 0, 0, 4, 1));
        // ld x3; addi with rs2 field 3 (held) no stall; sd rs2=3 stalls
        vt.push_back(mk(1, C_LD, 'h114, 1, 0, 3, 0, 0, 0,
                        0, 1, 1, C_LD, 1, 'h114, 1, 0, 3, 1));
        vt.push_back(mk(1, C_ADDI, 'h118, 1, 3, 6, 0, 1, 0,
                        0, 1, 1, C_LD, 1, 'h114, 1, 0, 3, 1));
        vt.push_back(mk(1, C_SD, 'h11c, 1, 3, 0, 0, 0, 0,
                        1, 1, 0, 0, 0, 0, 0, 0, 0, 2));
        vt.push_back(mk(1, C_SD, 'h11c, 1, 3, 0, 0, 0, 0,
                        0, 1, 1, C_SD, 1, 'h11c, 1, 3, 0, 2));
        // Flush beats hold and hazard; count unchanged
        vt.push_back(mk(1, C_LD, 'h120, 1, 0, 7, 0, 0, 0,
                        0, 1, 1, C_LD, 1, 'h120, 1, 0, 7, 2));
        vt.push_back(mk(1, C_R, 'h124, 7, 8, 9, 1, 1, 0,
                        0, 1, 0, 0, 0, 0, 0, 0, 0, 2));
        // Hold for 3 cycles while ID changes, then release
        vt.push_back(mk(1, C_LD, 'h128, 1, 0, 7, 0, 0, 0,
                        0, 1, 1, C_LD, 1, 'h128, 1, 0, 7, 2));
        vt.push_back(mk(1, C_R, 'h200, 1, 2, 10, 0, 1, 0,
                        0, 1, 1, C_LD, 1, 'h128, 1, 0, 7, 2));
        vt.push_back(mk(1, C_R, 'h204, 7, 2, 11, 0, 1, 0,
                        1, 1, 1, C_LD, 1, 'h128, 1, 0, 7, 2));
        vt.push_back(mk(1, C_R, 'h208, 1, 2, 12, 0, 1, 0,
                        0, 1, 1, C_LD, 1, 'h128, 1, 0, 7, 2));
        vt.push_back(mk(1, C_R, 'h20c, 1, 2, 13, 0, 0, 0,
                        0, 1, 1, C_R, 1, 'h20c, 1, 2, 13, 2));
        // Invalid ID passes controls with ex_valid low
        vt.push_back(mk(0, C_R, 'h210, 1, 2, 14, 0, 0, 0,
                        0, 1, 0, C_R, 1, 'h210, 1, 2, 14, 2));
        // Reset during a stall
        vt.push_back(mk(1, C_LD, 'h214, 1, 0, 7, 0, 0, 0,
                        0, 1, 1, C_LD, 1, 'h214, 1, 0, 7, 2));
        vt.push_back(mk(1, C_R, 'h218, 7, 8, 9, 0, 0, 1,
                        1, 1, 0, 0, 1, 0, 0, 0, 0, 0));

        #1;
        foreach (vt[i]) begin
            v = vt[i];
            drive(v);
            #1;
            if (v.c_stall) begin
                chk($sformatf("v%0d stall", i), 64'(stall), 64'(v.e_stall));
                chk($sformatf("v%0d pc_write", i), 64'(pc_write),
                    64'(!v.e_stall));
                chk($sformatf("v%0d if_id_write", i), 64'(if_id_write),
                    64'(!v.e_stall));
            end
            @(posedge clk);
            #1;
            chk($sformatf("v%0d ex_valid", i), 64'(ex_valid), 64'(v.e_vld));
            chk($sformatf("v%0d ctrl", i), 64'(ex_ctrl()), 64'(v.e_ctrl));
            chk($sformatf("v%0d count", i), 64'(bubble_count), 64'(v.e_cnt));
            if (v.c_data) begin
                chk($sformatf("v%0d pc", i), ex_pc, v.e_pc);
                chk($sformatf("v%0d rd", i), 64'(ex_rd), 64'(v.e_rd));
                chk($sformatf("v%0d rs1", i), 64'(ex_rs1), 64'(v.e_rs1));
                chk($sformatf("v%0d rs2", i), 64'(ex_rs2), 64'(v.e_rs2));
                chk($sformatf("v%0d rs1_data", i), ex_rs1_data,
                    v.rst ? 64'd0 : f_rs1d(v.e_pc));
                chk($sformatf("v%0d rs2_data", i), ex_rs2_data,
                    v.rst ? 64'd0 : f_rs2d(v.e_pc));
                chk($sformatf("v%0d imm", i), ex_imm,
                    v.rst ? 64'd0 : f_imm(v.e_pc));
                chk($sformatf("v%0d funct4", i), 64'(ex_funct4),
                    v.rst ? 64'd0 : 64'(f_f4(v.e_pc)));
            end
        end

        // ld x7,0(x7) repeated: bubble every other edge, 5 bubbles
        v = mk(1, C_LD, 'h300, 7, 0, 7, 0, 0, 0,
               0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(v);
        chk("sat start", 64'(s_bubble_count), 64'd0);
        for (k = 1; k <= 10; k++) begin
            #1;
            chk($sformatf("seq%0d stall", k), 64'(stall), 64'(k % 2 == 0));
            @(posedge clk);
            #1;
            ebub = k / 2;
            chk($sformatf("seq%0d ex_valid", k), 64'(ex_valid),
                64'(k % 2 == 1));
            chk($sformatf("seq%0d count", k), 64'(bubble_count),
                64'(ebub));
            chk($sformatf("seq%0d sat_count", k), 64'(s_bubble_count),
                64'(ebub > 3 ? 3 : ebub));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
